// File: rtl/key_debounce_toggle.sv
// Pushbutton conditioner: two-flop synchroniser, stable-count debouncer,
// one-cycle press/release pulses, debounced level and a press-driven pause toggle.
module key_debounce_toggle #(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter logic        KEY_ACTIVE      = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_in,
    output logic key_level,
    output logic key_press,
    output logic key_release,
    output logic pause
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        RELEASED     = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;

    logic             key_s1;
    logic             key_s2;
    logic             key_act;
    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             level_d;
    logic             press_d;
    logic             release_d;
    logic             pause_d;

    // Synchroniser; reset parks it at the released level so no false press appears.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            key_s1 <= ~KEY_ACTIVE;
            key_s2 <= ~KEY_ACTIVE;
        end else begin
            key_s1 <= key_in;
            key_s2 <= key_s1;
        end
    end

    assign key_act = (key_s2 == KEY_ACTIVE);

    // State, qualification counter and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= RELEASED;
            cnt_q       <= '0;
            key_level   <= 1'b0;
            key_press   <= 1'b0;
            key_release <= 1'b0;
            pause       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            key_level   <= level_d;
            key_press   <= press_d;
            key_release <= release_d;
            pause       <= pause_d;
        end
    end

    // Next state: any opposite sample in a WAIT state drops back and restarts.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        level_d   = key_level;
        press_d   = 1'b0;
        release_d = 1'b0;
        pause_d   = pause;

        case (state_q)
            RELEASED: begin
                if (key_act) begin
                    state_d = PRESS_WAIT;
                    cnt_d   = '0;
                end
            end
            PRESS_WAIT: begin
                if (!key_act) begin
                    state_d = RELEASED;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                    press_d = 1'b1;
                    level_d = 1'b1;
                    pause_d = ~pause;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            PRESSED: begin
                if (!key_act) begin
                    state_d = RELEASE_WAIT;
                    cnt_d   = '0;
                end
            end
            RELEASE_WAIT: begin
                if (key_act) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = RELEASED;
                    cnt_d     = '0;
                    release_d = 1'b1;
                    level_d   = 1'b0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = RELEASED;
                cnt_d   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_key_debounce_toggle.sv
// Bench for key_debounce_toggle: an active-low and an active-high instance driven with
// complementary keys, both checked against a run-length debounce model.
module tb_key_debounce_toggle;

    localparam int unsigned D = 4;

    logic clk;
    logic rst_n;
    logic key_lo;
    logic key_hi;
    logic lvl_lo, prs_lo, rel_lo, pau_lo;
    logic lvl_hi, prs_hi, rel_hi, pau_hi;

    int total = 0;
    int bad   = 0;

    assign key_hi = ~key_lo;

    key_debounce_toggle #(.DEBOUNCE_CYCLES(D), .KEY_ACTIVE(1'b0)) dut_lo (
        .clk(clk), .rst_n(rst_n), .key_in(key_lo),
        .key_level(lvl_lo), .key_press(prs_lo), .key_release(rel_lo), .pause(pau_lo)
    );

    key_debounce_toggle #(.DEBOUNCE_CYCLES(D), .KEY_ACTIVE(1'b1)) dut_hi (
        .clk(clk), .rst_n(rst_n), .key_in(key_hi),
        .key_level(lvl_hi), .key_press(prs_hi), .key_release(rel_hi), .pause(pau_hi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: the level flips once the synchronised key has disagreed with it on D+1
    // consecutive edges; any agreeing sample clears the run.
    logic        hist0, hist1;
    logic        m_lvl, m_press, m_rel, m_pause;
    int unsigned m_run;
    logic        m_disagree;

    assign m_disagree = ((hist1 == 1'b0) != m_lvl);

    always @(posedge clk) begin
        if (!rst_n) begin
            hist0 <= 1'b1; hist1 <= 1'b1;
            m_lvl <= 1'b0; m_press <= 1'b0; m_rel <= 1'b0; m_pause <= 1'b0;
            m_run <= 0;
        end else begin
            hist0 <= key_lo;
            hist1 <= hist0;
            m_press <= 1'b0;
            m_rel   <= 1'b0;
            if (!m_disagree) begin
                m_run <= 0;
            end else if (m_run == D) begin
                m_run   <= 0;
                m_lvl   <= ~m_lvl;
                m_press <= ~m_lvl;
                m_rel   <= m_lvl;
                if (!m_lvl) m_pause <= ~m_pause;
            end else begin
                m_run <= m_run + 1;
            end
        end
    end

    logic [7:0] obs;
    logic [7:0] mdl;
    assign obs = {lvl_lo, prs_lo, rel_lo, pau_lo, lvl_hi, prs_hi, rel_hi, pau_hi};
    assign mdl = {2{m_lvl, m_press, m_rel, m_pause}};

    // Drive key for the next edge, then settle to the following falling edge.
    task automatic step(input logic k);
        key_lo = k;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(i[0]);
            total++;
            if (obs !== 8'h00) begin
                bad++; $display("FAIL reset_outputs got=%b exp=%b", obs, 8'h00);
            end
        end
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step(1'b1);
            total++;
            if (obs !== 8'h00 || obs !== mdl) begin
                bad++; $display("FAIL idle_after_reset got=%b exp=%b", obs, 8'h00);
            end
        end
    endtask

    task automatic test_bounce_press;
        int npress = 0;
        for (int r = 0; r < 5; r++) begin
            for (int i = 0; i < 4; i++) begin
                step(i < 3 ? 1'b0 : 1'b1);
                total++;
                if (obs !== mdl) begin
                    bad++; $display("FAIL bounce_model got=%b exp=%b", obs, mdl);
                end
                if (prs_lo || prs_hi) npress++;
            end
        end
        for (int i = 0; i < 8; i++) begin
            step(1'b1);
            if (prs_lo || prs_hi) npress++;
        end
        total++;
        if (npress != 0 || lvl_lo !== 1'b0 || pau_lo !== 1'b0 || lvl_hi !== 1'b0) begin
            bad++; $display("FAIL bounce_reject got=press%0d/lvl%b/pause%b exp=press0/lvl0/pause0",
                            npress, lvl_lo, pau_lo);
        end
    endtask

    task automatic test_press(input logic exp_pause);
        int edge_lo = -1, edge_hi = -1, n_lo = 0, n_hi = 0;
        for (int i = 1; i <= 20; i++) begin
            step(1'b0);
            total++;
            if (obs !== mdl) begin
                bad++; $display("FAIL press_model edge=%0d got=%b exp=%b", i, obs, mdl);
            end
            if (prs_lo) begin n_lo++; edge_lo = i; end
            if (prs_hi) begin n_hi++; edge_hi = i; end
        end
        total++;
        if (edge_lo != 7 || n_lo != 1) begin
            bad++; $display("FAIL press_edge_lo got=%0d(x%0d) exp=7(x1)", edge_lo, n_lo);
        end
        total++;
        if (edge_hi != 7 || n_hi != 1) begin
            bad++; $display("FAIL press_edge_hi got=%0d(x%0d) exp=7(x1)", edge_hi, n_hi);
        end
        total++;
        if (lvl_lo !== 1'b1 || pau_lo !== exp_pause || pau_hi !== exp_pause) begin
            bad++; $display("FAIL press_state got=lvl%b/pause%b exp=lvl1/pause%b", lvl_lo, pau_lo, exp_pause);
        end
    endtask

    task automatic test_release;
        int edge_r = -1, n_r = 0;
        for (int i = 1; i <= 20; i++) begin
            step(1'b1);
            total++;
            if (obs !== mdl) begin
                bad++; $display("FAIL release_model edge=%0d got=%b exp=%b", i, obs, mdl);
            end
            if (rel_lo) begin n_r++; edge_r = i; end
        end
        total++;
        if (edge_r != 7 || n_r != 1) begin
            bad++; $display("FAIL release_edge got=%0d(x%0d) exp=7(x1)", edge_r, n_r);
        end
        total++;
        if (lvl_lo !== 1'b0 || pau_lo !== 1'b1 || lvl_hi !== 1'b0 || pau_hi !== 1'b1) begin
            bad++; $display("FAIL release_state got=lvl%b/pause%b exp=lvl0/pause1", lvl_lo, pau_lo);
        end
    endtask

    task automatic test_bouncy_release;
        int n_early = 0, edge_r = -1, n_r = 0;
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 3; i++) begin
                step(i < 2 ? 1'b1 : 1'b0);
                total++;
                if (obs !== mdl) begin
                    bad++; $display("FAIL bouncy_model got=%b exp=%b", obs, mdl);
                end
                if (rel_lo || rel_hi) n_early++;
            end
        end
        total++;
        if (n_early != 0 || lvl_lo !== 1'b1) begin
            bad++; $display("FAIL bouncy_reject got=rel%0d/lvl%b exp=rel0/lvl1", n_early, lvl_lo);
        end
        for (int i = 1; i <= 12; i++) begin
            step(1'b1);
            if (rel_lo) begin n_r++; edge_r = i; end
        end
        total++;
        if (edge_r != 7 || n_r != 1 || pau_lo !== 1'b0) begin
            bad++; $display("FAIL bouncy_release_edge got=%0d(x%0d)/pause%b exp=7(x1)/pause0",
                            edge_r, n_r, pau_lo);
        end
    endtask

    task automatic test_reset_mid_wait;
        int edge_p = -1, n_p = 0;
        for (int i = 0; i < 12; i++) step(1'b0);
        for (int i = 0; i < 12; i++) step(1'b1);
        total++;
        if (pau_lo !== 1'b1) begin
            bad++; $display("FAIL pre_reset_pause got=%b exp=1", pau_lo);
        end
        for (int i = 0; i < 4; i++) step(1'b0);
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step(1'b0);
            total++;
            if (obs !== 8'h00) begin
                bad++; $display("FAIL mid_wait_reset got=%b exp=%b", obs, 8'h00);
            end
        end
        rst_n = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            step(1'b0);
            total++;
            if (obs !== mdl) begin
                bad++; $display("FAIL post_reset_model edge=%0d got=%b exp=%b", i, obs, mdl);
            end
            if (prs_lo) begin n_p++; edge_p = i; end
        end
        total++;
        if (edge_p != 7 || n_p != 1 || pau_lo !== 1'b1) begin
            bad++; $display("FAIL post_reset_press got=%0d(x%0d)/pause%b exp=7(x1)/pause1",
                            edge_p, n_p, pau_lo);
        end
    endtask

    task automatic test_random;
        int n_both = 0;
        for (int b = 0; b < 80; b++) begin
            logic k;
            int   len;
            k   = 1'($urandom_range(0, 1));
            len = int'($urandom_range(1, 9));
            for (int i = 0; i < len; i++) begin
                step(k);
                total++;
                if (obs !== mdl) begin
                    bad++; $display("FAIL random_model burst=%0d got=%b exp=%b", b, obs, mdl);
                end
                if (prs_lo && rel_lo) n_both++;
            end
        end
        total++;
        if (n_both != 0) begin
            bad++; $display("FAIL pulse_overlap got=%0d exp=0", n_both);
        end
    endtask

    initial begin
        rst_n  = 1'b0;
        key_lo = 1'b1;
        test_reset();
        test_bounce_press();
        test_press(1'b1);
        test_release();
        test_press(1'b0);
        test_bouncy_release();
        test_reset_mid_wait();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
